// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths and latencies plus the MDU sequencer state type.
package cpu_pkg;

  localparam int REG_W    = 5;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;
  localparam int CNT_W    = 16;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs from the pipeline, write/flush enables back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = cpu_pkg::REG_W,
  parameter int CNT_W = cpu_pkg::CNT_W
);

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_MduStart;
  logic             ID_MduDiv;
  logic             ID_HiLoRead;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_Rd;
  logic             EX_BranchTaken;
  logic             Mem_Wait;

  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Write;
  logic             IDEX_Flush;
  logic             EXMEM_Write;
  logic             Mdu_Go;
  logic             Mdu_Busy;
  logic [CNT_W-1:0] Stall_Cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_MduStart, ID_MduDiv, ID_HiLoRead,
    output EX_MemRead, EX_Rd, EX_BranchTaken, Mem_Wait,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write,
    input  Mdu_Go, Mdu_Busy, Stall_Cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_MduStart, ID_MduDiv, ID_HiLoRead,
    input  EX_MemRead, EX_Rd, EX_BranchTaken, Mem_Wait,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write,
    output Mdu_Go, Mdu_Busy, Stall_Cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mdu_busy_fsm.sv
// MDU busy sequencer: issues the start pulse and tracks the remaining latency of the operation.
module mdu_busy_fsm
  import cpu_pkg::*;
#(
  parameter int MULT_LAT = cpu_pkg::MULT_LAT,
  parameter int DIV_LAT  = cpu_pkg::DIV_LAT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic start_ok,
  input  logic div,
  input  logic mem_wait,
  output logic mdu_go,
  output logic mdu_busy
);

  localparam int MAX_LAT = lat_max(MULT_LAT, DIV_LAT);
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and remaining-latency registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= MDU_IDLE;
      count_q <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state; the count is held while the pipeline is frozen by memory.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mdu_go  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_ok) begin
          state_d = MDU_BUSY;
          count_d = div ? DIV_LOAD : MUL_LOAD;
          mdu_go  = 1'b1;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      MDU_BUSY: begin
        if (mem_wait) begin
          count_d = count_q;
        end else if (count_q == CNT_ZERO) begin
          state_d = MDU_IDLE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  assign mdu_busy = Rst && (state_q == MDU_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: load-use and MDU hazard decode, enable priority and stall-cycle counter.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W    = cpu_pkg::REG_W,
  parameter int MULT_LAT = cpu_pkg::MULT_LAT,
  parameter int DIV_LAT  = cpu_pkg::DIV_LAT,
  parameter int CNT_W    = cpu_pkg::CNT_W
) (
  input  logic                   Clk,
  input  logic                   Rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             lu_hazard;
  logic             md_hazard;
  logic             start_ok;
  logic             stall_inc;
  logic             mdu_go;
  logic             mdu_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Hazard decode; an MDU start is taken only when the ID instruction really moves to EX.
  always_comb begin
    lu_hazard = hz.EX_MemRead && (hz.EX_Rd != REG_ZERO) &&
                ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_Rd)) ||
                 (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_Rd)));
    md_hazard = mdu_busy && (hz.ID_HiLoRead || hz.ID_MduStart);
    start_ok  = Rst && hz.ID_MduStart && !hz.Mem_Wait && !hz.EX_BranchTaken &&
                !lu_hazard && !md_hazard;
    stall_inc = hz.Mem_Wait || ((lu_hazard || md_hazard) && !hz.EX_BranchTaken);
  end

  mdu_busy_fsm #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu_fsm (
    .Clk      (Clk),
    .Rst      (Rst),
    .start_ok (start_ok),
    .div      (hz.ID_MduDiv),
    .mem_wait (hz.Mem_Wait),
    .mdu_go   (mdu_go),
    .mdu_busy (mdu_busy)
  );

  // Enable/flush priority: reset, memory freeze, taken branch, stall, normal flow.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    if (!Rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
    end else if (hz.Mem_Wait) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (hz.EX_BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu_hazard || md_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end else begin
      pc_write    = 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.PC_Write    = pc_write;
  assign hz.IFID_Write  = ifid_write;
  assign hz.IFID_Flush  = ifid_flush;
  assign hz.IDEX_Write  = idex_write;
  assign hz.IDEX_Flush  = idex_flush;
  assign hz.EXMEM_Write = exmem_write;
  assign hz.Mdu_Go      = mdu_go;
  assign hz.Mdu_Busy    = mdu_busy;
  assign hz.Stall_Cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs queued per step, compared at the falling edge.
module tb_pipeline_hazard_ctrl;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write}
  localparam logic [5:0] EN_NORM  = 6'b110101;
  localparam logic [5:0] EN_STALL = 6'b000111;
  localparam logic [5:0] EN_BR    = 6'b111111;
  localparam logic [5:0] EN_FRZ   = 6'b000000;
  localparam logic [5:0] EN_RST   = 6'b001010;

  typedef struct packed {
    logic [5:0] en;
    logic       go;
    logic       busy;
    logic [3:0] cnt;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4)) hz ();

  pipeline_hazard_ctrl #(
    .REG_W    (5),
    .MULT_LAT (4),
    .DIV_LAT  (32),
    .CNT_W    (4)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (hz)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'd15) ? 4'd15 : c + 4'd1;
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0; hz.ID_UsesRs = 1'b0; hz.ID_UsesRt = 1'b0;
    hz.ID_MduStart = 1'b0; hz.ID_MduDiv = 1'b0; hz.ID_HiLoRead = 1'b0;
    hz.EX_MemRead = 1'b0; hz.EX_Rd = 5'd0; hz.EX_BranchTaken = 1'b0; hz.Mem_Wait = 1'b0;
  endtask

  // Queue the expectation for the inputs just driven, then compare at the falling edge.
  task automatic step(input logic [5:0] en, input logic go, input logic busy);
    exp_t e;
    e.en = en; e.go = go; e.busy = busy; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge Clk);
    e = sb.pop_front();
    check("enables", {hz.PC_Write, hz.IFID_Write, hz.IFID_Flush,
                      hz.IDEX_Write, hz.IDEX_Flush, hz.EXMEM_Write}, e.en);
    check("mdu_go", {5'b00000, hz.Mdu_Go}, {5'b00000, e.go});
    check("mdu_busy", {5'b00000, hz.Mdu_Busy}, {5'b00000, e.busy});
    check("stall_cnt", {2'b00, hz.Stall_Cnt}, {2'b00, e.cnt});
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst = 1'b0;
    step(EN_RST, 1'b0, 1'b0);
    Rst = 1'b1;
    exp_cnt = 4'd0;
  endtask

  initial begin
    Rst = 1'b0;
    clear_inputs();
    exp_cnt = 4'd0;
    @(posedge Clk);
    #1;
    // Reset state, and a start under reset produces no pulse.
    step(EN_RST, 1'b0, 1'b0);
    hz.ID_MduStart = 1'b1;
    step(EN_RST, 1'b0, 1'b0);
    hz.ID_MduStart = 1'b0;
    Rst = 1'b1;
    step(EN_NORM, 1'b0, 1'b0);

    // Load-use on Rs, then on Rt; each stalls one cycle.
    hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd8; hz.ID_Rs = 5'd8; hz.ID_UsesRs = 1'b1;
    step(EN_STALL, 1'b0, 1'b0); exp_cnt = sat_inc(exp_cnt);
    hz.EX_MemRead = 1'b0;
    step(EN_NORM, 1'b0, 1'b0);
    hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd9; hz.ID_Rt = 5'd9; hz.ID_UsesRt = 1'b1; hz.ID_UsesRs = 1'b0;
    step(EN_STALL, 1'b0, 1'b0); exp_cnt = sat_inc(exp_cnt);
    hz.EX_MemRead = 1'b0;
    step(EN_NORM, 1'b0, 1'b0);
    // Load to $0 and an unused-operand match are not hazards.
    hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd0; hz.ID_Rs = 5'd0; hz.ID_UsesRs = 1'b1; hz.ID_Rt = 5'd0;
    step(EN_NORM, 1'b0, 1'b0);
    hz.EX_Rd = 5'd9; hz.ID_Rt = 5'd9; hz.ID_UsesRt = 1'b0; hz.ID_Rs = 5'd8;
    step(EN_NORM, 1'b0, 1'b0);

    // Multiply followed by mflo: four stall cycles.
    do_reset();
    hz.ID_MduStart = 1'b1;
    step(EN_NORM, 1'b1, 1'b0);
    hz.ID_MduStart = 1'b0; hz.ID_HiLoRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(EN_STALL, 1'b0, 1'b1); exp_cnt = sat_inc(exp_cnt);
    end
    step(EN_NORM, 1'b0, 1'b0);
    hz.ID_HiLoRead = 1'b0;

    // Divide with three memory-wait cycles, then a second start held off by MD.
    do_reset();
    hz.ID_MduStart = 1'b1; hz.ID_MduDiv = 1'b1;
    step(EN_NORM, 1'b1, 1'b0);
    clear_inputs();
    for (int i = 0; i < 5; i++) step(EN_NORM, 1'b0, 1'b1);
    hz.Mem_Wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(EN_FRZ, 1'b0, 1'b1); exp_cnt = sat_inc(exp_cnt);
    end
    hz.Mem_Wait = 1'b0;
    for (int i = 0; i < 25; i++) step(EN_NORM, 1'b0, 1'b1);
    hz.ID_MduStart = 1'b1; hz.ID_MduDiv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(EN_STALL, 1'b0, 1'b1); exp_cnt = sat_inc(exp_cnt);
    end
    step(EN_NORM, 1'b1, 1'b0);
    hz.ID_MduStart = 1'b0;
    step(EN_NORM, 1'b0, 1'b1);
    // Reset mid-BUSY abandons the operation.
    Rst = 1'b0; hz.ID_MduStart = 1'b1;
    step(EN_RST, 1'b0, 1'b0);
    Rst = 1'b1; clear_inputs(); exp_cnt = 4'd0;
    step(EN_NORM, 1'b0, 1'b0);
    step(EN_NORM, 1'b0, 1'b0);

    // Taken branch overrides load-use and start.
    hz.EX_BranchTaken = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd8;
    hz.ID_Rs = 5'd8; hz.ID_UsesRs = 1'b1; hz.ID_MduStart = 1'b1;
    step(EN_BR, 1'b0, 1'b0);
    clear_inputs();
    step(EN_NORM, 1'b0, 1'b0);
    // Freeze beats branch; branch applies once memory is ready.
    hz.EX_BranchTaken = 1'b1; hz.Mem_Wait = 1'b1;
    step(EN_FRZ, 1'b0, 1'b0); exp_cnt = sat_inc(exp_cnt);
    hz.Mem_Wait = 1'b0;
    step(EN_BR, 1'b0, 1'b0);
    clear_inputs();
    step(EN_NORM, 1'b0, 1'b0);

    // Long freeze saturates the 4-bit counter; a frozen start only issues afterwards.
    hz.Mem_Wait = 1'b1; hz.ID_MduStart = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(EN_FRZ, 1'b0, 1'b0); exp_cnt = sat_inc(exp_cnt);
    end
    hz.Mem_Wait = 1'b0;
    step(EN_NORM, 1'b1, 1'b0);
    clear_inputs();
    step(EN_NORM, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall controller for the five-stage pipelined CPU. It decides each cycle whether PC, IF/ID and ID/EX advance, hold, or are flushed. It sequences the multi-cycle multiply/divide unit (MDU) through an internal busy FSM and keeps a saturating stall-cycle counter for debug readout on the seven-segment display path. It sits beside the ID stage and drives the pipeline-register write and flush enables of the CPU top.

## Interface
- REG_W, 5, register-address width
- MULT_LAT, 4, MDU multiply latency in cycles (>=1)
- DIV_LAT, 32, MDU divide latency in cycles (>=1)
- CNT_W, 16, stall-counter width
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-low reset
- ID_Rs, ID_Rt  in  REG_W  source registers of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1  ID instruction actually reads Rs / Rt
- ID_MduStart  in  1  ID instruction is mult/multu/div/divu
- ID_MduDiv  in  1  1 = divide, 0 = multiply (valid with ID_MduStart)
- ID_HiLoRead  in  1  ID instruction is mfhi/mflo
- EX_MemRead  in  1  EX instruction is a load
- EX_Rd  in  REG_W  destination register of EX instruction
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- Mem_Wait  in  1  data memory not ready; freeze pipeline
- PC_Write  out  1  PC loads next value
- IFID_Write  out  1  IF/ID register loads
- IFID_Flush  out  1  IF/ID register loads a NOP
- IDEX_Write  out  1  ID/EX register loads
- IDEX_Flush  out  1  ID/EX register loads a bubble
- EXMEM_Write  out  1  EX/MEM and MEM/WB registers load
- Mdu_Go  out  1  one-cycle start pulse to MDU
- Mdu_Busy  out  1  MDU result not yet valid
- Stall_Cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Hazard conditions, evaluated every cycle:
  - LU (load-use): EX_MemRead && EX_Rd!=0 && ((ID_UsesRs && ID_Rs==EX_Rd) || (ID_UsesRt && ID_Rt==EX_Rd)).
  - MD (MDU hazard): Mdu_Busy && (ID_HiLoRead || ID_MduStart).
- Priority, highest first:
  - Mem_Wait: all write enables 0, all flushes 0 (full freeze).
  - EX_BranchTaken: PC_Write=1, IFID_Flush=1, IDEX_Flush=1, IDEX_Write=1, EXMEM_Write=1; overrides LU/MD because the ID instruction is wrong-path.
  - LU or MD: PC_Write=0, IFID_Write=0, IDEX_Flush=1 (bubble), IDEX_Write=1, EXMEM_Write=1.
  - Otherwise: all writes 1, all flushes 0.
- When a flush is asserted, the corresponding write is also 1.
- MDU FSM states:
  - IDLE: Mdu_Busy=0.
  - BUSY: Mdu_Busy=1; count register decrements each cycle not under Mem_Wait.
- MDU FSM transitions:
  - IDLE->BUSY when ID_MduStart is accepted. Accepted means ID advances this cycle: no Mem_Wait, no EX_BranchTaken, no MD. Acceptance fires Mdu_Go=1 for that cycle and loads count = (ID_MduDiv ? DIV_LAT : MULT_LAT) - 1.
  - BUSY->IDLE when count==0 and no Mem_Wait.
  - A start is never accepted in BUSY; MD stalls it until IDLE.
  - A flushed or frozen start never produces Mdu_Go.
- Count width: $clog2(max(MULT_LAT,DIV_LAT)) bits.
- Stall_Cnt increments by 1 on each cycle with Mem_Wait, or with (LU||MD) && !EX_BranchTaken. It saturates at all-ones.
- Reset (Rst==0 at a rising edge): FSM->IDLE, count->0, Stall_Cnt->0.
- While Rst is low, outputs are forced to:
  - PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Write=0
  - IFID_Flush=1, IDEX_Flush=1
  - Mdu_Go=0, Mdu_Busy=0
- Reset mid-BUSY abandons the MDU operation; no Mdu_Go is issued.

## Timing
- Enable/flush outputs and Mdu_Go are combinational from inputs and registered state, with zero latency, for same-cycle use by the pipeline registers.
- Mdu_Busy and Stall_Cnt are registered-state outputs.
- Mdu_Go at edge-cycle T: Mdu_Busy=1 for cycles T+1 .. T+LAT. An mfhi/mflo in ID at T+LAT+1 proceeds without stall. Each Mem_Wait cycle during BUSY extends this by one cycle.
- LU stall lasts exactly 1 cycle. After the bubble, EX no longer holds the load.
- Simultaneous EX_BranchTaken and Mem_Wait: the freeze wins. The branch is re-evaluated next cycle because EX is held.

## Structure
- Shared package `cpu_pkg`: REG_W, MULT_LAT, DIV_LAT defaults; MDU state enum {MDU_IDLE, MDU_BUSY}.
- One sub-module, `mdu_busy_fsm`: state, count, Mdu_Go/Mdu_Busy.
- Hazard decode, priority logic and Stall_Cnt stay in the top.

## Test plan
- Load-use: EX_MemRead=1, EX_Rd=8, ID_Rs=8, ID_UsesRs=1 → exactly one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1, Stall_Cnt 0→1. EX_Rd=0 gives no stall.
- Multiply then mflo next cycle (MULT_LAT=4) → Mdu_Go one cycle; mflo stalls 4 cycles; Mdu_Busy high 4 cycles; Stall_Cnt=4.
- Divide with Mem_Wait=1 for 3 cycles mid-BUSY (DIV_LAT=32) → Mdu_Busy high 35 cycles; all writes 0 during the waits.
- EX_BranchTaken with a load-use hazard and ID_MduStart in ID → IFID_Flush=IDEX_Flush=1, PC_Write=1, no Mdu_Go, Stall_Cnt unchanged.
- CNT_W=4, hold Mem_Wait 20 cycles → Stall_Cnt saturates at 15.
- Rst low for 1 cycle during BUSY → Mdu_Busy=0 next cycle, Stall_Cnt=0, flushes 1 while Rst low.
